// File: rtl/simon_decrypt_ctrl.sv
// Sequencing controller for an iterative SIMON32/64 decrypt core: accepts one
// ciphertext/key block, steps the core through all rounds and returns the plaintext.
module simon_decrypt_ctrl #(
    parameter int ROUNDS = 32,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ct,
    input  logic [63:0]      in_key,
    input  logic             abort,
    output logic             core_load,
    output logic [CNT_W-1:0] core_count,
    output logic [31:0]      core_text,
    output logic [63:0]      core_key,
    input  logic [31:0]      core_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pt,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] ct_r;
    logic [63:0] key_r;

    // Holding registers feed the core for the whole block, isolating it from the input bus.
    assign core_text = ct_r;
    assign core_key  = key_r;

    // Controller state machine; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            ct_r       <= 32'd0;
            key_r      <= 64'd0;
            in_ready   <= 1'b1;
            core_load  <= 1'b0;
            core_count <= '0;
            out_valid  <= 1'b0;
            out_pt     <= 32'd0;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        ct_r       <= in_ct;
                        key_r      <= in_key;
                        state_r    <= LOAD;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        core_load  <= 1'b1;
                        core_count <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    core_load  <= 1'b0;
                    core_count <= '0;
                    if (abort) begin
                        state_r  <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    // Abort outranks completion so a cancelled block never reaches DONE.
                    if (abort) begin
                        state_r    <= IDLE;
                        core_count <= '0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b0;
                    end else if (core_count == LAST_ROUND) begin
                        state_r    <= DONE;
                        core_count <= '0;
                        out_pt     <= core_result;
                        out_valid  <= 1'b1;
                    end else begin
                        core_count <= core_count + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    core_load  <= 1'b0;
                    core_count <= '0;
                    out_valid  <= 1'b0;
                    in_ready   <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_decrypt_ctrl.sv
// Directed bench for simon_decrypt_ctrl with a behavioural SIMON32/64 decrypt core
// attached; expected plaintexts come from the published vector or a reference encryptor.
module tb_simon_decrypt_ctrl;

    localparam int ROUNDS = 32;
    localparam int CNT_W  = 5;
    localparam logic [31:0] KAT_CT  = 32'hC69BE9BB;
    localparam logic [63:0] KAT_KEY = 64'h1918111009080100;
    localparam logic [31:0] KAT_PT  = 32'h65656877;
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_ct;
    logic [63:0]      in_key;
    logic             abort;
    logic             core_load;
    logic [CNT_W-1:0] core_count;
    logic [31:0]      core_text;
    logic [63:0]      core_key;
    logic [31:0]      core_result;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pt;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    simon_decrypt_ctrl #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ct(in_ct), .in_key(in_key), .abort(abort), .core_load(core_load),
        .core_count(core_count), .core_text(core_text), .core_key(core_key),
        .core_result(core_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_pt(out_pt), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rol16(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [15:0] ror16(input logic [15:0] v, input int n);
        return (v >> n) | (v << (16 - n));
    endfunction

    function automatic logic [15:0] f16(input logic [15:0] x);
        return (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2);
    endfunction

    function automatic logic [31:0][15:0] expand(input logic [63:0] key);
        logic [31:0][15:0] k;
        logic [15:0]       tmp;
        logic [61:0]       z;
        z    = Z0;
        k    = '0;
        k[0] = key[15:0];
        k[1] = key[31:16];
        k[2] = key[47:32];
        k[3] = key[63:48];
        for (int i = 0; i < 28; i++) begin
            tmp      = ror16(k[i+3], 3) ^ k[i+1];
            tmp      = tmp ^ ror16(tmp, 1);
            k[i+4]   = k[i] ^ tmp ^ 16'hFFFC ^ {15'd0, z[61-i]};
        end
        return k;
    endfunction

    function automatic logic [31:0] encrypt(input logic [31:0] p, input logic [63:0] key);
        logic [31:0][15:0] k;
        logic [15:0]       x, y, t;
        k = expand(key);
        x = p[31:16];
        y = p[15:0];
        for (int i = 0; i < ROUNDS; i++) begin
            t = x;
            x = y ^ f16(x) ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    // Behavioural decrypt core: latches on core_load, else advances one round per clock.
    logic [31:0][15:0] core_rk;
    logic [31:0]       core_st;
    always @(posedge clk) begin
        if (core_load) begin
            core_st <= core_text;
            core_rk <= expand(core_key);
        end else begin
            core_st <= core_result;
        end
    end
    assign core_result = {core_st[15:0],
                          core_st[31:16] ^ f16(core_st[15:0]) ^ core_rk[ROUNDS - 1 - int'(core_count)]};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_block(input logic [31:0] ct, input logic [63:0] key,
                             input logic [31:0] pt, input int hold, input bit abt);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ct     = ct;
        in_key    = key;
        abort     = abt;
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
        in_ct    = ~ct;
        in_key   = ~key;
        check_eq("load", {core_load, core_count, in_ready, busy}, {1'b1, 5'd0, 1'b0, 1'b1});
        for (int r = 0; r < ROUNDS; r++) begin
            @(negedge clk);
            check_eq("run", {core_load, core_count, out_valid}, {1'b0, 5'(r), 1'b0});
        end
        @(negedge clk);
        check_eq("done_valid", {out_valid, in_ready, busy}, {1'b1, 1'b0, 1'b1});
        check_eq("plaintext", out_pt, pt);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold", {out_valid, in_ready, out_pt}, {1'b1, 1'b0, pt});
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("back_idle", {out_valid, in_ready, busy}, {1'b0, 1'b1, 1'b0});
        out_ready = 1'b0;
    endtask

    task automatic wait_count(input logic [CNT_W-1:0] n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (busy && !core_load && core_count == n) ok = 1'b1;
            else @(negedge clk);
        end
        check_eq("wait_count", {63'd0, ok}, 64'd1);
    endtask

    logic [31:0] pt2, ct2, pt3, ct3;
    logic [63:0] key2, key3;
    logic [31:0] pts[2];
    int          acc_t[2];
    int          acc, outs, first_out;
    bit          seen, pend;

    initial begin
        pt2  = 32'h1234ABCD;  key2 = 64'h0F1E2D3C4B5A6978;
        pt3  = 32'hA5A55A5A;  key3 = 64'hFEDCBA9876543210;
        ct2  = encrypt(pt2, key2);
        ct3  = encrypt(pt3, key3);
        rst = 1'b0; in_valid = 1'b0; in_ct = 32'd0; in_key = 64'd0;
        abort = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("reset_idle", {in_ready, out_valid, core_load, core_count, busy},
                     {1'b1, 1'b0, 1'b0, 5'd0, 1'b0});
        end
        check_eq("reset_pt", out_pt, 32'd0);

        run_block(KAT_CT, KAT_KEY, KAT_PT, 0, 1'b0);
        run_block(KAT_CT, KAT_KEY, KAT_PT, 20, 1'b0);

        // Abort mid-run, then a fresh block must still decrypt.
        @(negedge clk);
        in_valid = 1'b1; in_ct = KAT_CT; in_key = KAT_KEY;
        @(negedge clk);
        in_valid = 1'b0;
        wait_count(5'd17);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_idle", {in_ready, busy, core_load, core_count, out_valid},
                 {1'b1, 1'b0, 1'b0, 5'd0, 1'b0});
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check_eq("abort_no_out", {63'd0, seen}, 64'd0);
        run_block(ct2, key2, pt2, 0, 1'b0);

        // Asynchronous reset mid-run, sampled before the next rising edge.
        @(negedge clk);
        in_valid = 1'b1; in_ct = KAT_CT; in_key = KAT_KEY;
        @(negedge clk);
        in_valid = 1'b0;
        wait_count(5'd9);
        #2 rst = 1'b0;
        #1 check_eq("async_reset", {in_ready, out_valid, core_load, core_count, busy, out_pt},
                    {1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0});
        @(negedge clk);
        rst = 1'b1;
        run_block(ct3, key3, pt3, 0, 1'b1);

        // Back-to-back with in_valid and out_ready held high.
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_ct = KAT_CT; in_key = KAT_KEY;
        acc = 0; outs = 0; first_out = -1; pend = 1'b0;
        pts[0] = 32'd0; pts[1] = 32'd0; acc_t[0] = 0; acc_t[1] = 0;
        for (int cyc = 0; cyc < 150 && outs < 2; cyc++) begin
            if (pend) begin
                pend = 1'b0;
                if (acc == 1) begin
                    in_ct = ct2; in_key = key2;
                end else begin
                    in_valid = 1'b0; in_ct = 32'hDEADBEEF; in_key = 64'd0;
                end
            end
            if (out_valid) begin
                if (outs == 0) first_out = cyc;
                pts[outs] = out_pt;
                outs++;
            end
            if (in_valid && in_ready && acc < 2) begin
                acc_t[acc] = cyc;
                acc++;
                pend = 1'b1;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("b2b_outputs", 64'(outs), 64'd2);
        check_eq("b2b_pt0", pts[0], KAT_PT);
        check_eq("b2b_pt1", pts[1], pt2);
        check_eq("b2b_gap", 64'(acc_t[1] - acc_t[0]), 64'd35);
        check_eq("b2b_latency", 64'(first_out - acc_t[0]), 64'd34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simon_decrypt_ctrl.md
Name: simon_decrypt_ctrl

Overview:
Sequencing controller for the SIMON32/64 iterative decrypt core. Accepts a 32-bit ciphertext block and 64-bit key over a valid/ready handshake. It then drives the core's load pulse and 5-bit round count through 32 rounds, captures the recovered plaintext and presents it on a valid/ready output. It sits between the system-side stream interface and the decrypt cipher core: one block in flight, no overlap.

Parameters:
ROUNDS, 32, number of decrypt rounds sequenced (SIMON32/64 fixed).
CNT_W, 5, width of the round counter and core count port; 2**CNT_W must be >= ROUNDS.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  ciphertext/key offered
in_ready  output  1  controller can accept a block
in_ct  input  32  ciphertext block
in_key  input  64  64-bit key, word 0 in [15:0]
abort  input  1  synchronous cancel of the block in flight
core_load  output  1  load strobe to the core
core_count  output  CNT_W  round index to the core
core_text  output  32  block driven into the core's data input
core_key  output  64  key driven into the core
core_result  input  32  core round output (combinational next state)
out_valid  output  1  plaintext available
out_ready  input  1  downstream accepts plaintext
out_pt  output  32  recovered plaintext
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; in_ready=1; core_load=0; core_count=0; out_valid=0; out_pt=0; ct/key holding registers=0; busy=0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at edge E0, register in_ct and in_key, then go to LOAD. Holding registers drive core_text/core_key continuously.
- LOAD (1 cycle): core_load=1, core_count=0. Go to RUN at edge E1; the core latches block and key words here.
- RUN: core_load=0. core_count increments by 1 each cycle, 0..ROUNDS-1; RUN lasts ROUNDS cycles.
  - In the cycle core_count==ROUNDS-1, out_pt<=core_result at edge E(ROUNDS+1) and state goes to DONE.
  - Counter resets to 0 on leaving RUN. It never wraps inside RUN.
- DONE: out_valid=1, out_pt stable. On out_valid&out_ready, go to IDLE with out_valid=0 the next cycle. No new input is accepted in DONE.
- Latency: out_valid rises ROUNDS+1 (=33) cycles after the input handshake edge. Minimum throughput is ROUNDS+3 cycles per block with out_ready held high.
- Backpressure: DONE holds indefinitely with out_pt/out_valid unchanged while out_ready=0.
- abort=1 in LOAD or RUN: next state IDLE, core_count=0, core_load=0, no out_valid for that block. abort in IDLE/DONE is ignored. abort has priority over round completion in the same cycle.
- Input handshake in IDLE with abort=1: the accept still occurs (abort is ignored in IDLE).
- in_ct/in_key changes after acceptance have no effect on the block in flight.
- Asynchronous reset mid-RUN or in DONE: immediate return to reset values; the block is lost and out_valid drops without a handshake.
- busy = (state != IDLE); in_ready = (state == IDLE).
- core_load is asserted for exactly one cycle per accepted block, never in RUN/DONE.

Test Plan:
- Reset, then hold in_valid=0 -> in_ready=1, out_valid=0, core_load=0, core_count=0, busy=0 for 10 cycles.
- Accept in_ct=32'hC69BE9BB, in_key=64'h1918111009080100 with the real core attached -> core_load for 1 cycle, core_count steps 0..31, out_valid 33 cycles after accept with out_pt=32'h65656877.
- Same vector with out_ready=0 for 20 cycles after out_valid -> out_pt/out_valid stable, in_ready=0. Raise out_ready -> one handshake, IDLE next cycle.
- Assert abort when core_count==17 -> IDLE next cycle, no out_valid. A following block then decrypts correctly.
- Drive rst=0 asynchronously when core_count==9 -> all outputs at reset values before the next clock edge. Resume with a new block -> correct plaintext.
- Back-to-back blocks with out_ready=1 and in_valid held high -> second accept 35 cycles after the first, both plaintexts correct, in_ct changed after accept ignored.
